// File: rtl/gpu_pkg.sv
// Shared miniGPU definitions: core pipeline state encoding, fetcher and LSU
// state constants, and the default program-counter width.
package gpu_pkg;

  localparam int unsigned PC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  // A lane holds the pipeline in WAIT while its memory access is in flight.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/lane_pc_select.sv
// Combinational converged-PC selector.
// Picks next_pc of the lowest-index active lane (lane 0 when no lane is active).
// Macro SCHED_DIVERGE_CHECK_EN adds a divergence flag: any active lane whose
// next_pc differs from the selected one.
// Ports:
//   thread_mask [LANES]      - 1 = lane active
//   next_pc     [PC_W*LANES] - per-lane next PC, lane i at [PC_W*i +: PC_W]
//   sel_pc      [PC_W]       - selected PC
//   diverge     (macro only) - active lanes disagree on next PC
module lane_pc_select
  import gpu_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned PC_W  = PC_W_DEFAULT
) (
  input  logic [LANES-1:0]      thread_mask,
  input  logic [PC_W*LANES-1:0] next_pc,
  output logic [PC_W-1:0]       sel_pc
`ifdef SCHED_DIVERGE_CHECK_EN
  ,
  output logic                  diverge
`endif
);

  logic found;

  always_comb begin
    sel_pc = next_pc[PC_W-1:0];
    found  = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!found && thread_mask[i]) begin
        sel_pc = next_pc[PC_W*i +: PC_W];
        found  = 1'b1;
      end
    end
  end

`ifdef SCHED_DIVERGE_CHECK_EN
  // Comparing each active lane against the winner is equivalent to a
  // pairwise comparison of all active lanes.
  always_comb begin
    diverge = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (thread_mask[i] && (next_pc[PC_W*i +: PC_W] != sel_pc)) begin
        diverge = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/core_scheduler.sv
// Per-core pipeline sequencer for the miniGPU.
// Steps FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE on fetch and
// LSU handshakes, selects the converged PC, reports block completion and a
// saturating count of active cycles.
// Optional macro SCHED_DIVERGE_CHECK_EN: sticky diverge_err when active lanes
// disagree on next PC in UPDATE; otherwise diverge_err is tied to 0.
// Ports:
//   clk, reset (sync, active-high)
//   start         - begin from PC 0 when IDLE
//   thread_mask   - active lanes
//   fetcher_state - fetcher FSM state (FETCHED = 3'b010)
//   decoded_ret   - current instruction is RET
//   lsu_state     - per-lane LSU state, lane i at [2i+1:2i]
//   next_pc       - per-lane next PC, lane i at [PC_W*i +: PC_W]
//   core_state    - pipeline state broadcast
//   current_pc    - PC presented to the fetcher
//   done          - sticky block-finished flag
//   cycle_count   - cycles spent outside IDLE/DONE (saturating)
//   diverge_err   - sticky divergence flag
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_W              = 8,
  parameter int unsigned CYC_W             = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [THREADS_PER_BLOCK-1:0]   thread_mask,
  input  logic [2:0]                     fetcher_state,
  input  logic                           decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state,
  input  logic [PC_W*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                     core_state,
  output logic [PC_W-1:0]                current_pc,
  output logic                           done,
  output logic [CYC_W-1:0]               cycle_count,
  output logic                           diverge_err
);

  core_state_e state, state_next;
  logic        busy;
  logic [PC_W-1:0] sel_pc;

`ifdef SCHED_DIVERGE_CHECK_EN
  logic sel_diverge;
`endif

  lane_pc_select #(
    .LANES (THREADS_PER_BLOCK),
    .PC_W  (PC_W)
  ) u_sel (
    .thread_mask (thread_mask),
    .next_pc     (next_pc),
    .sel_pc      (sel_pc)
`ifdef SCHED_DIVERGE_CHECK_EN
    ,
    .diverge     (sel_diverge)
`endif
  );

  assign core_state = state;

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_mask[i] && lsu_busy(lsu_state[2*i +: 2])) begin
        busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CORE_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CORE_IDLE:    if (start) state_next = CORE_FETCH;
      CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_next = CORE_DECODE;
      CORE_DECODE:  state_next = CORE_REQUEST;
      CORE_REQUEST: state_next = CORE_WAIT;
      CORE_WAIT:    if (!busy) state_next = CORE_EXECUTE;
      CORE_EXECUTE: state_next = CORE_UPDATE;
      CORE_UPDATE:  state_next = decoded_ret ? CORE_DONE : CORE_FETCH;
      CORE_DONE:    state_next = CORE_DONE;
      default:      state_next = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc  <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        CORE_IDLE: begin
          if (start) begin
            current_pc  <= '0;
            cycle_count <= '0;
          end
        end
        CORE_UPDATE: begin
          if (decoded_ret) done <= 1'b1;
          else             current_pc <= sel_pc;
        end
        default: ;
      endcase
      if ((state != CORE_IDLE) && (state != CORE_DONE) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
    end
  end

`ifdef SCHED_DIVERGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      diverge_err <= 1'b0;
    end else if ((state == CORE_UPDATE) && !decoded_ret && sel_diverge) begin
      diverge_err <= 1'b1;
    end
  end
`else
  assign diverge_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
module tb_core_scheduler;

  localparam int unsigned T = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned CW = 16;
`ifdef SCHED_DIVERGE_CHECK_EN
  localparam logic DIV_EXP = 1'b1;
`else
  localparam logic DIV_EXP = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                         S_REQ = 3'b011, S_WAIT = 3'b100, S_EXEC = 3'b101,
                         S_UPD = 3'b110, S_DONE = 3'b111;

  logic          clk = 1'b0;
  logic          reset, start, decoded_ret;
  logic [T-1:0]  thread_mask;
  logic [2:0]    fetcher_state;
  logic [2*T-1:0] lsu_state;
  logic [PW*T-1:0] next_pc;
  logic [2:0]    core_state;
  logic [PW-1:0] current_pc;
  logic          done;
  logic [CW-1:0] cycle_count;
  logic          diverge_err;

  int checks = 0;
  int failures = 0;

  core_scheduler #(
    .THREADS_PER_BLOCK (T),
    .PC_W              (PW),
    .CYC_W             (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_mask   (thread_mask),
    .fetcher_state (fetcher_state),
    .decoded_ret   (decoded_ret),
    .lsu_state     (lsu_state),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .done          (done),
    .cycle_count   (cycle_count),
    .diverge_err   (diverge_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // From FETCH: one-cycle fetch, no LSU stall, ends with state UPDATE.
  task automatic run_plain(input string tag);
    fetcher_state = 3'b010;
    step(); chk({tag, "_decode"}, core_state, S_DECODE);
    fetcher_state = 3'b000;
    step(); chk({tag, "_request"}, core_state, S_REQ);
    step(); chk({tag, "_wait"}, core_state, S_WAIT);
    step(); chk({tag, "_execute"}, core_state, S_EXEC);
    step(); chk({tag, "_update"}, core_state, S_UPD);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; decoded_ret = 1'b0;
    thread_mask = 4'hF; fetcher_state = 3'b000; lsu_state = '0;
    next_pc = {4{8'h01}};

    // Reset state
    step();
    chk("rst_state", core_state, S_IDLE);
    chk("rst_pc", current_pc, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_div", diverge_err, 0);

    // Start, 3-cycle fetch, full instruction
    reset = 1'b0; start = 1'b1;
    step(); chk("st_fetch1", core_state, S_FETCH);
    start = 1'b0;
    step(); chk("st_fetch2", core_state, S_FETCH);
    step(); chk("st_fetch3", core_state, S_FETCH);
    fetcher_state = 3'b010;
    step(); chk("st_decode", core_state, S_DECODE);
    fetcher_state = 3'b000;
    step(); chk("st_request", core_state, S_REQ);
    step(); chk("st_wait", core_state, S_WAIT);
    step(); chk("st_execute", core_state, S_EXEC);
    step(); chk("st_update", core_state, S_UPD);
    step(); chk("st_fetch_next", core_state, S_FETCH);
    chk("st_pc", current_pc, 8'h01);
    chk("st_cnt", cycle_count, 8);

    // LSU wait: lane1 gates, masked lane2 ignored
    thread_mask = 4'b1011;
    lsu_state = 8'b00_10_10_00;
    fetcher_state = 3'b010;
    step(); chk("lw_decode", core_state, S_DECODE);
    fetcher_state = 3'b000;
    step(); chk("lw_request", core_state, S_REQ);
    step(); chk("lw_wait1", core_state, S_WAIT);
    step(); chk("lw_wait2", core_state, S_WAIT);
    step(); chk("lw_wait3", core_state, S_WAIT);
    lsu_state = 8'b00_10_11_00;
    step(); chk("lw_execute", core_state, S_EXEC);
    lsu_state = '0;
    step(); chk("lw_update", core_state, S_UPD);

    // PC select: lowest active lane wins
    thread_mask = 4'b1100;
    next_pc = {8'h40, 8'h30, 8'h20, 8'h10};
    step(); chk("ps_fetch", core_state, S_FETCH);
    chk("ps_pc_1100", current_pc, 8'h30);
    chk("ps_cnt", cycle_count, 16);
    chk("ps_div_1100", diverge_err, DIV_EXP);

    // Empty mask: WAIT passes in one cycle despite a busy lane; lane0 PC used
    thread_mask = 4'b0000;
    lsu_state = 8'b10_10_10_10;
    run_plain("m0");
    lsu_state = '0;
    step(); chk("m0_fetch", core_state, S_FETCH);
    chk("m0_pc", current_pc, 8'h10);
    chk("m0_cnt", cycle_count, 22);

    // RET: DONE, done sticky, counter frozen, start ignored
    thread_mask = 4'b0001;
    next_pc = {8'hAA, 8'hAA, 8'hAA, 8'hAA};
    run_plain("ret");
    decoded_ret = 1'b1;
    step(); chk("ret_state", core_state, S_DONE);
    chk("ret_done", done, 1);
    chk("ret_pc", current_pc, 8'h10);
    chk("ret_cnt", cycle_count, 28);
    decoded_ret = 1'b0;
    start = 1'b1;
    step(); start = 1'b0;
    step();
    start = 1'b1;
    step(); start = 1'b0;
    chk("dn_state", core_state, S_DONE);
    chk("dn_done", done, 1);
    chk("dn_cnt", cycle_count, 28);
    chk("dn_pc", current_pc, 8'h10);

    // Reset out of DONE
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("rd_state", core_state, S_IDLE);
    chk("rd_done", done, 0);
    chk("rd_cnt", cycle_count, 0);
    chk("rd_pc", current_pc, 0);
    step(); chk("rd_idle_hold", core_state, S_IDLE);

    // Restart, reach PC 0xFF, then reset mid-WAIT with lane0 busy
    start = 1'b1;
    step(); start = 1'b0;
    chk("rs_fetch", core_state, S_FETCH);
    chk("rs_pc", current_pc, 0);
    chk("rs_cnt", cycle_count, 0);
    next_pc = {8'h00, 8'h00, 8'h00, 8'hFF};
    run_plain("rs");
    step(); chk("rs_pc_ff", current_pc, 8'hFF);
    lsu_state = 8'b00_00_00_01;
    fetcher_state = 3'b010;
    step(); fetcher_state = 3'b000;
    step();
    step(); chk("mw_wait1", core_state, S_WAIT);
    step(); chk("mw_wait2", core_state, S_WAIT);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("mw_state", core_state, S_IDLE);
    chk("mw_pc", current_pc, 0);
    chk("mw_cnt", cycle_count, 0);
    lsu_state = '0;
    start = 1'b1;
    step(); start = 1'b0;
    chk("mw_restart", core_state, S_FETCH);
    chk("mw_restart_pc", current_pc, 0);

    // Divergence: masked-off lanes ignored, then active lanes disagree
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("dv_rst", diverge_err, 0);
    start = 1'b1;
    step(); start = 1'b0;
    thread_mask = 4'b0011;
    next_pc = {8'h77, 8'h66, 8'h05, 8'h05};
    run_plain("dv0");
    step(); chk("dv0_pc", current_pc, 8'h05);
    chk("dv0_flag", diverge_err, 0);
    next_pc = {8'h77, 8'h66, 8'h09, 8'h05};
    run_plain("dv1");
    step(); chk("dv1_pc", current_pc, 8'h05);
    chk("dv1_flag", diverge_err, DIV_EXP);
    next_pc = {8'h00, 8'h00, 8'h07, 8'h07};
    run_plain("dv2");
    step(); chk("dv2_pc", current_pc, 8'h07);
    chk("dv2_sticky", diverge_err, DIV_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
